dbg_mem_responder: RTL and testbench
====================================

# dbg_mem_responder

Responder side of the debug-to-memory path: accepts read/write requests from the JTAG debug module, performs them on the single-port instruction memory, and returns a response with read data and an error flag. It sits between `jtag_top` and `rom`. It owns the memory read port while the core is halted and passes the core fetch through otherwise. Debug writes and reads are fully handshaked.

## Interface
- `DW`, 32, data width
- `AW`, 32, byte-address width
- `MEM_NUM`, 4096, memory depth in words; the address range check uses this value

- `clk` in 1, clock
- `rstn` in 1, reset, synchronous, active-low
- `halt` in 1, core halted; the debug side may read only when this is 1
- `req_valid` in 1, debug request valid
- `req_ready` out 1, responder can accept a request
- `req_we` in 1, 1 = write, 0 = read
- `req_addr` in AW, byte address
- `req_wdata` in DW, write data
- `resp_valid` out 1, response valid
- `resp_ready` in 1, debug side accepts the response
- `resp_rdata` out DW, read data; 0 for writes and for errors
- `resp_err` out 1, access rejected
- `core_addr` in AW, core fetch address
- `mem_wen` out 1, memory write strobe
- `mem_waddr` out AW, memory write address
- `mem_wdata` out DW, memory write data
- `mem_raddr` out AW, memory read address
- `mem_rdata` in DW, memory read data; registered, 1-cycle latency

## Operation
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - A request is accepted when `req_valid && req_ready`. On acceptance the responder latches `req_we`, the address and `req_wdata`.
- Error check at acceptance: the request is rejected if any of these holds:
  - `addr[1:0]!=0`
  - `addr[AW-1:2] >= MEM_NUM`
  - read with `halt`=0
- On error: go to RESP with `resp_err`=1 and `resp_rdata`=0. No memory access is made.
- WR:
  - `mem_wen`=1 for exactly one cycle, with `mem_waddr`/`mem_wdata` taken from the latched values.
  - Then go to RESP with `resp_err`=0.
  - Writes are allowed with `halt`=0.
- RD_ISSUE: `mem_raddr` = latched address. Go to RD_WAIT.
- RD_WAIT: capture `mem_rdata` into `resp_rdata`. Go to RESP.
- RESP:
  - `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until `resp_ready`.
  - Leave to IDLE on `resp_valid && resp_ready`.
- Read-port mux:
  - `mem_raddr` = latched address in RD_ISSUE.
  - `mem_raddr` = `core_addr` in all other states.
- `halt` falling during RD_ISSUE or RD_WAIT does not abort the read; the read completes normally.
- Reset mid-transaction: return to IDLE, drop any pending response, deassert `mem_wen` immediately.

## Timing
- Reset values:
  - state IDLE
  - `req_ready`=1
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0
  - `mem_wen`=0, `mem_waddr`=0, `mem_wdata`=0
  - `mem_raddr` follows `core_addr`
- Write latency: acceptance at cycle N → `mem_wen` at N+1 → `resp_valid` at N+2.
- Read latency: acceptance at N → `mem_raddr` driven at N+1 → data captured at N+2 → `resp_valid` at N+3.
- Error latency: acceptance at N → `resp_valid` at N+1.
- `req_ready` is 0 in every state except IDLE. There is no request pipelining.
- `resp_ready` held at 1 gives back-to-back throughput of one write per 3 cycles and one read per 4 cycles.
- The core fetch read port is taken for exactly one cycle per debug read.

## Configuration
- Macro: `DBG_MEM_AUTOINC_EN`.
- Defined:
  - Adds input `req_seq` (1 bit).
  - An internal `next_addr` register, reset 0, loads the access address + 4 after every successful access.
  - A request with `req_seq`=1 uses `next_addr` instead of `req_addr`. The error check applies to the substituted address.
  - On error, `next_addr` is unchanged.
  - Wrap-around at 2^AW is not special-cased; the range check rejects the access.
- Undefined: no `req_seq` port and no `next_addr` register; every access uses `req_addr`.

## Structure
- Package `dbg_mem_pkg`:
  - state enum
  - `ADDR_ALIGN_MASK` constant
  - response error-reason localparams, internal debug only: `ERR_ALIGN`, `ERR_RANGE`, `ERR_RUNNING`
- One sub-module: `dbg_mem_addr_chk`, combinational. Takes address and halt, returns the error flag; parameterised by `AW` and `MEM_NUM`.

## Test plan
- Write 0xDEADBEEF to addr 0x10 with `halt`=0 → `mem_wen` pulses once with `mem_waddr`=0x10; `resp_valid` 2 cycles after acceptance; `resp_err`=0.
- With `halt`=1 and mem[0x10]=0xDEADBEEF, read 0x10 → `mem_raddr`=0x10 for one cycle; `resp_rdata`=0xDEADBEEF; `resp_valid` 3 cycles after acceptance.
- Read 0x10 with `halt`=0 → `resp_err`=1, `resp_rdata`=0, no `mem_raddr` takeover.
- Access 0x12, then 0x4000 with `MEM_NUM`=4096 → both give `resp_err`=1 and no `mem_wen`.
- Hold `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_rdata`, `resp_err` stable and `req_ready`=0 throughout; assert `rstn`=0 mid-RD_WAIT → IDLE, `resp_valid`=0 next cycle.
- `DBG_MEM_AUTOINC_EN`: write 0x100, then two `req_seq`=1 writes → `mem_waddr` sequence 0x100, 0x104, 0x108.

Source files
------------

// File: rtl/dbg_mem_pkg.sv
// Shared types and constants for the debug-to-memory responder.
// Used by dbg_mem_responder and dbg_mem_addr_chk.
package dbg_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

  // Reject reasons, kept for internal debug visibility only
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_RUNNING = 2'd3;

endpackage

// File: rtl/dbg_mem_addr_chk.sv
// Combinational legality check for a debug access: word alignment,
// memory range, and reads only while the core is halted.
module dbg_mem_addr_chk
  import dbg_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int MEM_NUM = 4096
) (
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic          i_halt,
  output logic          o_err
);

  logic [1:0] w_reason;

  always_comb begin
    w_reason = ERR_NONE;
    if ((i_addr[1:0] & ADDR_ALIGN_MASK) != 2'b00)
      w_reason = ERR_ALIGN;
    else if (i_addr[AW-1:2] >= (AW-2)'(MEM_NUM))
      w_reason = ERR_RANGE;
    else if (!i_we && !i_halt)
      w_reason = ERR_RUNNING;
  end

  assign o_err = (w_reason != ERR_NONE);

endmodule

// File: rtl/dbg_mem_responder.sv
// Debug-side responder for the instruction memory: handshaked read/write
// with error response. Optional auto-increment via DBG_MEM_AUTOINC_EN.
module dbg_mem_responder
  import dbg_mem_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_NUM = 4096
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          halt,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
`ifdef DBG_MEM_AUTOINC_EN
  input  logic          req_seq,
`endif
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  input  logic [AW-1:0] core_addr,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_mem_wen;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_rdata;
  logic          r_resp_err;
  logic [AW-1:0] w_addr;
  logic          w_err;

`ifdef DBG_MEM_AUTOINC_EN
  logic [AW-1:0] r_next_addr;

  // Only completed accesses advance the sequential pointer; errors leave it
  always_ff @(posedge clk) begin
    if (!rstn)
      r_next_addr <= '0;
    else if (r_state == WR || r_state == RD_WAIT)
      r_next_addr <= r_addr + AW'(4);
  end

  assign w_addr = req_seq ? r_next_addr : req_addr;
`else
  assign w_addr = req_addr;
`endif

  dbg_mem_addr_chk #(
    .AW      (AW),
    .MEM_NUM (MEM_NUM)
  ) u_addr_chk (
    .i_addr (w_addr),
    .i_we   (req_we),
    .i_halt (halt),
    .o_err  (w_err)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_wen    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_addr       <= w_addr;
            r_wdata      <= req_wdata;
            r_resp_rdata <= '0;
            r_resp_err   <= w_err;
            r_req_ready  <= 1'b0;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else if (req_we) begin
              r_mem_wen <= 1'b1;
              r_state   <= WR;
            end else begin
              r_state <= RD_ISSUE;
            end
          end
        end
        WR: begin
          r_mem_wen    <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RD_ISSUE: r_state <= RD_WAIT;
        // Halt is deliberately ignored here: a started read always completes
        RD_WAIT: begin
          r_resp_rdata <= mem_rdata;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_mem_wen    <= 1'b0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_wen    = r_mem_wen;
  assign mem_waddr  = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_raddr  = (r_state == RD_ISSUE) ? r_addr : core_addr;

endmodule

// File: tb/tb_dbg_mem_responder.sv
// Randomized scoreboard bench for dbg_mem_responder with a word-array
// memory model; define DBG_MEM_AUTOINC_EN to exercise req_seq.
module tb_dbg_mem_responder;

  localparam int MEM_NUM = 4096;
  localparam logic [31:0] CORE_ADDR = 32'hFFFF_FFF0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accCycle;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        halt = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_seq = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] core_addr = CORE_ADDR;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata = '0;

  resp_t       respQ[$];
  wr_t         wrQ[$];
  logic [31:0] rdAddrQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          respMode = 1;
  logic [31:0] rom [MEM_NUM];
  bit          romWritten [MEM_NUM];
  logic [31:0] refMem [MEM_NUM];
  bit          refWritten [MEM_NUM];
  logic [31:0] refNext = '0;
  logic        prevValid = 1'b0;
  logic [31:0] heldRdata;
  logic        heldErr;

  dbg_mem_responder #(.DW(32), .AW(32), .MEM_NUM(MEM_NUM)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .halt       (halt),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DBG_MEM_AUTOINC_EN
    .req_seq    (req_seq),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .core_addr  (core_addr),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  function automatic logic [31:0] initVal(int idx);
    return 32'hA500_0000 ^ (32'(idx) * 32'h0001_0203);
  endfunction

  // Word-addressed memory with one-cycle registered read
  always @(posedge clk) begin
    mem_rdata <= romWritten[mem_raddr[13:2]] ? rom[mem_raddr[13:2]] : initVal(int'(mem_raddr[13:2]));
    if (mem_wen) begin
      rom[mem_waddr[13:2]]        <= mem_wdata;
      romWritten[mem_waddr[13:2]] <= 1'b1;
    end
  end

  // Response back-pressure pattern, changed just after each rising edge
  always @(posedge clk) begin
    #2;
    case (respMode)
      0:       resp_ready = ($urandom_range(0, 3) != 0);
      2:       resp_ready = 1'b0;
      default: resp_ready = 1'b1;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: DUT produced an event with nothing expected (cycle %0d)", name, cycle);
  endtask

  // Monitor: memory strobes, read-port takeovers and responses
  always @(negedge clk) begin
    if (!rstn) begin
      prevValid = 1'b0;
    end else begin
      if (mem_wen) begin
        if (wrQ.size() == 0) reportMissing("mem_wen_unexpected");
        else begin
          wr_t w;
          w = wrQ.pop_front();
          checkOutput("mem_waddr", mem_waddr, w.addr);
          checkOutput("mem_wdata", mem_wdata, w.data);
        end
      end
      if (mem_raddr !== core_addr) begin
        if (rdAddrQ.size() == 0) reportMissing("mem_raddr_takeover");
        else checkOutput("mem_raddr", mem_raddr, rdAddrQ.pop_front());
      end
      if (resp_valid) begin
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        if (!prevValid) begin
          heldRdata = resp_rdata;
          heldErr   = resp_err;
          if (respQ.size() == 0) reportMissing("resp_valid_unexpected");
          else checkOutput("resp_latency", 32'(cycle - respQ[0].accCycle), 32'(respQ[0].lat));
        end else begin
          checkOutput("resp_rdata_stable", resp_rdata, heldRdata);
          checkOutput("resp_err_stable", 32'(resp_err), 32'(heldErr));
        end
        if (resp_ready && respQ.size() > 0) begin
          resp_t r;
          r = respQ.pop_front();
          checkOutput("resp_rdata", resp_rdata, r.rdata);
          checkOutput("resp_err", 32'(resp_err), 32'(r.err));
        end
      end
      prevValid = resp_valid && !resp_ready;
    end
  end

  // Drive one request, let the reference model predict the outcome
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic hlt, input logic seq);
    int          waitCnt;
    logic [31:0] effAddr;
    logic        err;
    int          idx;
    resp_t       r;
    wr_t         w;
    waitCnt = 0;
    @(negedge clk);
    while (!req_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_ready_timeout: got 0, expected 1 within 100 cycles");
      return;
    end
    effAddr = addr;
`ifdef DBG_MEM_AUTOINC_EN
    if (seq) effAddr = refNext;
`endif
    halt      = hlt;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_seq   = seq;
    req_valid = 1'b1;
    err = (effAddr % 4 != 0) || ((effAddr / 4) >= MEM_NUM) || (!we && !hlt);
    idx = int'(effAddr / 4);
    r.err = err;
    r.accCycle = cycle;
    r.rdata = 32'd0;
    if (err) r.lat = 1;
    else if (we) begin
      r.lat = 2;
      w.addr = effAddr;
      w.data = wdata;
      wrQ.push_back(w);
      refMem[idx] = wdata;
      refWritten[idx] = 1'b1;
      refNext = effAddr + 32'd4;
    end else begin
      r.lat = 3;
      r.rdata = refWritten[idx] ? refMem[idx] : initVal(idx);
      rdAddrQ.push_back(effAddr);
      refNext = effAddr + 32'd4;
    end
    respQ.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    halt = 1'(($urandom_range(0, 3) == 0) ? 0 : hlt);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((respQ.size() != 0 || wrQ.size() != 0 || rdAddrQ.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return (32'($urandom_range(0, MEM_NUM - 1)) << 2) | 32'($urandom_range(1, 3));
      1:       return 32'h0000_4000 + (32'($urandom_range(0, 255)) << 2);
      2:       return $urandom | 32'h8000_0000;
      3:       return 32'h0000_3FFC;
      default: return 32'($urandom_range(0, 63)) << 2;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("reset_mem_waddr", mem_waddr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_mem_raddr", mem_raddr, CORE_ADDR);
    rstn = 1'b1;

    // Directed cases: write while running, read back, error classes, edges
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h12, 32'h1111_2222, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h4000, 32'h3333_4444, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h12, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h3FFC, 32'hCAFE_F00D, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h3FFC, 32'h0, 1'b1, 1'b0);
    drain();

    // Response held off for several cycles
    respMode = 2;
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    respMode = 1;
    drain();

    // Reset while the read is waiting for memory data
    @(negedge clk);
    halt = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h20;
    req_valid = 1'b1;
    rdAddrQ.push_back(32'h20);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    refNext = 32'd0;
    @(negedge clk);
    checkOutput("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);

`ifdef DBG_MEM_AUTOINC_EN
    applyStimulus(1'b1, 32'h100, 32'h0000_0A0A, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 32'h0000_0B0B, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0, 32'h0000_0C0C, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    drain();
`endif

    respMode = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end
    respMode = 1;
    drain();

    checkOutput("resp_queue_empty", 32'(respQ.size()), 32'd0);
    checkOutput("write_queue_empty", 32'(wrQ.size()), 32'd0);
    checkOutput("read_queue_empty", 32'(rdAddrQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
